// File: rtl/reg_file_2r1w_param_pkg.sv
// Shared constants, clear-FSM state type and index-width helper for the
// parametrised 2-read/1-write register file.
package reg_file_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DEPTH      = 32;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } clr_state_e;

  // Bits needed to index DEPTH entries (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_file_2r1w_param_if.sv
// Request/response bundle between decode/writeback and the register file.
interface reg_file_2r1w_param_if
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  READ;
  logic                  WRITE;
  logic                  CLEAR;
  logic [ADDR_WIDTH-1:0] ADDR_R1;
  logic [ADDR_WIDTH-1:0] ADDR_R2;
  logic [ADDR_WIDTH-1:0] ADDR_W;
  logic [DATA_WIDTH-1:0] DATA_W;
  logic [DATA_WIDTH-1:0] DATA_R1;
  logic [DATA_WIDTH-1:0] DATA_R2;
  logic                  RVALID;
  logic                  BUSY;

  modport master (
    output READ, WRITE, CLEAR, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
    input  DATA_R1, DATA_R2, RVALID, BUSY
  );

  modport slave (
    input  READ, WRITE, CLEAR, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
    output DATA_R1, DATA_R2, RVALID, BUSY
  );
endinterface

// File: rtl/reg_file_2r1w_param_clear_seq.sv
// Bulk-clear sequencer: walks the clear index 0..DEPTH-1, one entry per cycle,
// and holds BUSY for exactly DEPTH cycles.
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  output logic             o_busy,
  output logic             o_clr_en,
  output logic [IDX_W-1:0] o_clr_idx
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  clr_state_e       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_busy;

  // Clear FSM with registered BUSY; a CLEAR seen while clearing is ignored.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_clear) begin
            r_state <= ST_CLEARING;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_CLEARING: begin
          if (r_idx == LAST_IDX) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_idx <= r_idx + IDX_W'(1'b1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_clr_en  = (r_state == ST_CLEARING);
  assign o_clr_idx = r_idx;

endmodule

// File: rtl/reg_file_2r1w_param.sv
// Parametrised register file: two registered read ports with write bypass,
// one write port, range-checked addresses and a multi-cycle bulk clear.
// Optional build macro REG_FILE_ZERO_REG_EN hardwires register 0 to zero.
module reg_file_2r1w_param
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  reg_file_2r1w_param_if.slave bus
);
  localparam int                  IDX_W     = idx_width(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
`ifdef REG_FILE_ZERO_REG_EN
  localparam logic ZERO_REG = 1'b1;
`else
  localparam logic ZERO_REG = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_r1;
  logic [DATA_WIDTH-1:0] r_data_r2;
  logic                  r_rvalid;

  logic                  w_busy;
  logic                  w_clr_en;
  logic [IDX_W-1:0]      w_clr_idx;
  logic                  w_idle;
  logic                  w_rd_en;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_rd1;
  logic [DATA_WIDTH-1:0] w_rd2;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_LIM);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Out-of-range and hardwired-zero addresses read as zero and never bypass.
  function automatic logic [DATA_WIDTH-1:0] rd_port(
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  we,
    input logic [ADDR_WIDTH-1:0] aw,
    input logic [DATA_WIDTH-1:0] dw
  );
    if (!in_range(a) || is_zero_reg(a)) begin
      return '0;
    end else if (we && (a == aw)) begin
      return dw;
    end else begin
      return r_mem[a[IDX_W-1:0]];
    end
  endfunction

  reg_file_clear_seq #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_clear_seq (
    .i_clk     (CLK),
    .i_rst_n   (RST),
    .i_clear   (bus.CLEAR),
    .o_busy    (w_busy),
    .o_clr_en  (w_clr_en),
    .o_clr_idx (w_clr_idx)
  );

  // An accepted CLEAR blocks the read and write of the same edge.
  assign w_idle  = !w_busy;
  assign w_rd_en = w_idle && bus.READ && !bus.CLEAR;
  assign w_wr_en = w_idle && bus.WRITE && !bus.CLEAR
                   && in_range(bus.ADDR_W) && !is_zero_reg(bus.ADDR_W);

  // Read-data selection for both ports.
  always_comb begin
    w_rd1 = rd_port(bus.ADDR_R1, w_wr_en, bus.ADDR_W, bus.DATA_W);
    w_rd2 = rd_port(bus.ADDR_R2, w_wr_en, bus.ADDR_W, bus.DATA_W);
  end

  // Storage array: clear sweep has priority over writes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_clr_en) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_en) begin
      r_mem[bus.ADDR_W[IDX_W-1:0]] <= bus.DATA_W;
    end
  end

  // Registered read outputs and one-cycle RVALID.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data_r1 <= '0;
      r_data_r2 <= '0;
      r_rvalid  <= 1'b0;
    end else if (w_rd_en) begin
      r_data_r1 <= w_rd1;
      r_data_r2 <= w_rd2;
      r_rvalid  <= 1'b1;
    end else begin
      r_rvalid  <= 1'b0;
    end
  end

  assign bus.DATA_R1 = r_data_r1;
  assign bus.DATA_R2 = r_data_r2;
  assign bus.RVALID  = r_rvalid;
  assign bus.BUSY    = w_busy;

endmodule

// File: tb/tb_reg_file_2r1w_param.sv
// Scoreboard bench: two register files (DEPTH 32 and DEPTH 20) driven with the
// same stimulus and checked against an array-based reference model.
module tb_reg_file_2r1w_param;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTHS [2] = '{32, 20};
`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef struct {
    int unsigned   issue;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  exp_t          q_a[$];
  exp_t          q_b[$];
  logic [DW-1:0] mem [2][32];
  int            busy_cnt [2];

  reg_file_2r1w_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_a ();
  reg_file_2r1w_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_b ();

  reg_file_2r1w_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(32)) dut_a (
    .CLK (clk), .RST (rst_n), .bus (if_a)
  );
  reg_file_2r1w_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(20)) dut_b (
    .CLK (clk), .RST (rst_n), .bus (if_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int d, input logic [AW-1:0] a,
                                               input bit wv, input logic [AW-1:0] aw,
                                               input logic [DW-1:0] dw);
    if (int'(a) >= DEPTHS[d]) return '0;
    if (ZERO_REG && a == '0) return '0;
    if (wv && a == aw) return dw;
    return mem[d][a];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      busy_cnt[d] = 0;
      for (int i = 0; i < 32; i++) mem[d][i] = '0;
    end
    q_a.delete();
    q_b.delete();
  endtask

  // Reference: clear empties the whole file at once and blocks access for DEPTH cycles.
  task automatic model_step(input int d, input bit rd, input bit wr, input bit clr,
                            input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                            input logic [AW-1:0] aw, input logic [DW-1:0] dw);
    bit   wv;
    exp_t e;
    if (busy_cnt[d] > 0) begin
      busy_cnt[d]--;
    end else if (clr) begin
      busy_cnt[d] = DEPTHS[d];
      for (int i = 0; i < 32; i++) mem[d][i] = '0;
    end else begin
      wv = wr && (int'(aw) < DEPTHS[d]) && !(ZERO_REG && aw == '0);
      if (rd) begin
        e.issue = cyc + 1;
        e.d1 = model_read(d, a1, wv, aw, dw);
        e.d2 = model_read(d, a2, wv, aw, dw);
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
      end
      if (wv) mem[d][aw] = dw;
    end
  endtask

  // Drive one cycle on both DUTs (called just after a falling edge).
  task automatic cycle(input bit rd, input bit wr, input bit clr,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [AW-1:0] aw, input logic [DW-1:0] dw);
    if_a.READ = rd;  if_a.WRITE = wr;  if_a.CLEAR = clr;
    if_a.ADDR_R1 = a1; if_a.ADDR_R2 = a2; if_a.ADDR_W = aw; if_a.DATA_W = dw;
    if_b.READ = rd;  if_b.WRITE = wr;  if_b.CLEAR = clr;
    if_b.ADDR_R1 = a1; if_b.ADDR_R2 = a2; if_b.ADDR_W = aw; if_b.DATA_W = dw;
    model_step(0, rd, wr, clr, a1, a2, aw, dw);
    model_step(1, rd, wr, clr, a1, a2, aw, dw);
    @(posedge clk);
    @(negedge clk);
    check("busy_a", DW'(if_a.BUSY), DW'(busy_cnt[0] > 0));
    check("busy_b", DW'(if_b.BUSY), DW'(busy_cnt[1] > 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
  endtask

  task automatic mon(input int d, input logic rv, input logic [DW-1:0] r1, input logic [DW-1:0] r2);
    exp_t e;
    if (rv) begin
      if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL rvalid_%0d: got unexpected RVALID=1 expected 0 (cycle %0d)", d, cyc);
      end else begin
        e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
        check(d == 0 ? "latency_a" : "latency_b", DW'(cyc), DW'(e.issue));
        check(d == 0 ? "data_r1_a" : "data_r1_b", r1, e.d1);
        check(d == 0 ? "data_r2_a" : "data_r2_b", r2, e.d2);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents read data.
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, if_a.RVALID, if_a.DATA_R1, if_a.DATA_R2);
      mon(1, if_b.RVALID, if_b.DATA_R1, if_b.DATA_R2);
    end
  end

  initial begin
    model_reset();
    if_a.READ = 1'b0; if_a.WRITE = 1'b0; if_a.CLEAR = 1'b0;
    if_a.ADDR_R1 = '0; if_a.ADDR_R2 = '0; if_a.ADDR_W = '0; if_a.DATA_W = '0;
    if_b.READ = 1'b0; if_b.WRITE = 1'b0; if_b.CLEAR = 1'b0;
    if_b.ADDR_R1 = '0; if_b.ADDR_R2 = '0; if_b.ADDR_W = '0; if_b.DATA_W = '0;
    repeat (2) @(negedge clk);
    check("rst_r1_a", if_a.DATA_R1, 32'h0);
    check("rst_r2_b", if_b.DATA_R2, 32'h0);
    check("rst_rvalid_a", DW'(if_a.RVALID), 32'h0);
    check("rst_busy_b", DW'(if_b.BUSY), 32'h0);
    rst_n = 1'b1;

    // Write then read, and a plain idle cycle to catch a stretched RVALID.
    cycle(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7, 32'hDEADBEEF);
    cycle(1'b1, 1'b0, 1'b0, 5'd7, 5'd3, 5'd0, 32'h0);
    idle(2);

    // Bypass on both ports, then a plain read-back.
    cycle(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5, 32'h11111111);
    cycle(1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 32'h22222222);
    cycle(1'b1, 1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0);

    // Range: address 25 is out of range only for the DEPTH-20 file.
    cycle(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd19, 32'h19191919);
    cycle(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd25, 32'hA5A5A5A5);
    cycle(1'b1, 1'b1, 1'b0, 5'd25, 5'd19, 5'd25, 32'h5A5A5A5A);
    cycle(1'b1, 1'b0, 1'b0, 5'd25, 5'd19, 5'd0, 32'h0);

    // Register 0 write with simultaneous read.
    cycle(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 5'd1, 5'd0, 32'h0);

    // Clear sweep: CLEAR wins over a same-edge write; mid-sweep access is ignored.
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'(i), 32'(i));
    cycle(1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 5'd9, 32'h99999999);
    idle(5);
    cycle(1'b1, 1'b1, 1'b1, 5'd31, 5'd0, 5'd3, 32'hBADBAD00);
    idle(30);
    cycle(1'b1, 1'b0, 1'b0, 5'd31, 5'd0, 5'd0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 5'd9, 5'd3, 5'd0, 32'h0);

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 600; i++)
      cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0),
            5'($urandom), 5'($urandom), 5'($urandom), $urandom);

    // Reset in the middle of a clear aborts it immediately.
    idle(40);
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'(i), 32'hC0DE0000 | 32'(i));
    cycle(1'b1, 1'b0, 1'b0, 5'd30, 5'd12, 5'd0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0);
    idle(10);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_mid_busy_a", DW'(if_a.BUSY), 32'h0);
    check("rst_mid_busy_b", DW'(if_b.BUSY), 32'h0);
    check("rst_mid_r1_a", if_a.DATA_R1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 5'd31, 5'd15, 5'd0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 5'd19, 5'd1, 5'd0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0);
    idle(34);

    for (int i = 0; i < 300; i++)
      cycle(1'($urandom), 1'($urandom), ($urandom_range(0, 59) == 0),
            5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    idle(3);

    check("drain_a", DW'(q_a.size()), 32'h0);
    check("drain_b", DW'(q_b.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
